// File: rtl/chrom_seg_sequencer_if.sv
// Bus and segment-stream signals of the chromosome segment sequencer.
// The slave side is the sequencer; the master side is the CPU/datapath environment.
interface chrom_seg_sequencer_if;
   logic [3:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [31:0] seg_data;
   logic [2:0]  seg_index;
   logic        seg_valid;
   logic        seg_ready;
   logic        irq;

   modport slave (
      input  address, chipselect, write_n, writedata, seg_ready,
      output readdata, seg_data, seg_index, seg_valid, irq
   );

   modport master (
      output address, chipselect, write_n, writedata, seg_ready,
      input  readdata, seg_data, seg_index, seg_valid, irq
   );
endinterface

// File: rtl/chrom_seg_sequencer.sv
// Avalon-MM register bank that streams up to N_SEGS 32-bit chromosome segments
// into the evaluation datapath over valid/ready, with a settle gap between segments.
module chrom_seg_sequencer #(
   parameter int N_SEGS = 8,
   parameter int GAP_W  = 8
) (
   input logic                  clk,
   input logic                  reset,
   chrom_seg_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

   localparam logic [3:0] MAX_CNT = 4'(N_SEGS);

   state_t             state_q, state_d;
   logic [31:0]        seg_q [N_SEGS];
   logic               irq_en_q, done_q, aborted_q, wr_err_q;
   logic [3:0]         num_q, cnt_q;
   logic [GAP_W-1:0]   gap_q, gap_cnt_q;
   logic [2:0]         idx_q;

   logic wr, ctrl_wr, stat_wr, seg_sel, busy;
   logic start_req, abort_req, last_seg, xfer;
   logic load_run, advance, load_gap;

   assign wr        = bus.chipselect && !bus.write_n;
   assign ctrl_wr   = wr && (bus.address == 4'd0);
   assign stat_wr   = wr && (bus.address == 4'd1);
   assign seg_sel   = bus.address[3] && ({1'b0, bus.address[2:0]} < MAX_CNT);
   assign busy      = (state_q != IDLE);
   // ABORT wins over START when both arrive in one write
   assign start_req = ctrl_wr && bus.writedata[0] && !bus.writedata[1];
   assign abort_req = ctrl_wr && bus.writedata[1];
   assign last_seg  = ({1'b0, idx_q} == (cnt_q - 4'd1));
   assign xfer      = (state_q == SEND) && bus.seg_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      load_run = 1'b0;
      advance  = 1'b0;
      load_gap = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_req) begin
               load_run = 1'b1;
               state_d  = (num_q == 4'd0) ? FIN : SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (last_seg) begin
                  state_d = FIN;
               end else begin
                  advance = 1'b1;
                  if (gap_q == '0) begin
                     state_d = SEND;
                  end else begin
                     load_gap = 1'b1;
                     state_d  = GAP;
                  end
               end
            end
         end
         GAP:     if (gap_cnt_q == GAP_W'(1)) state_d = SEND;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (busy && abort_req) begin
         state_d  = IDLE;
         advance  = 1'b0;
         load_gap = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the segment bank is a small register file with a defined reset value, so it is reset like any flop.
         for (int i = 0; i < N_SEGS; i++) seg_q[i] <= '0;
         irq_en_q  <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         wr_err_q  <= 1'b0;
         num_q     <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         idx_q     <= '0;
      end else begin
         if (load_run) begin
            idx_q <= '0;
            cnt_q <= (num_q > MAX_CNT) ? MAX_CNT : num_q;
         end
         if (advance) idx_q <= idx_q + 3'd1;

         if (load_gap)              gap_cnt_q <= gap_q;
         else if (state_q == GAP)   gap_cnt_q <= gap_cnt_q - GAP_W'(1);

         if (ctrl_wr) irq_en_q <= bus.writedata[2];

         // Clears first, then sets, so a flag raised this cycle survives its W1C
         if (stat_wr && bus.writedata[1]) done_q    <= 1'b0;
         if (stat_wr && bus.writedata[2]) aborted_q <= 1'b0;
         if (stat_wr && bus.writedata[3]) wr_err_q  <= 1'b0;
         if ((state_q == FIN) && !abort_req) done_q <= 1'b1;
         if (busy && abort_req)             aborted_q <= 1'b1;

         if (wr && ((bus.address == 4'd2) || (bus.address == 4'd3) || seg_sel)) begin
            if (busy) begin
               wr_err_q <= 1'b1;
            end else if (bus.address == 4'd2) begin
               num_q <= bus.writedata[3:0];
            end else if (bus.address == 4'd3) begin
               gap_q <= bus.writedata[GAP_W-1:0];
            end else begin
               seg_q[bus.address[2:0]] <= bus.writedata;
            end
         end
      end
   end

   always_comb begin
      bus.readdata = '0;
      if (bus.address == 4'd0)      bus.readdata = {29'b0, irq_en_q, 2'b0};
      else if (bus.address == 4'd1) bus.readdata = {21'b0, idx_q, 4'b0, wr_err_q, aborted_q, done_q, busy};
      else if (bus.address == 4'd2) bus.readdata = {28'b0, num_q};
      else if (bus.address == 4'd3) bus.readdata = 32'(gap_q);
      else if (seg_sel)             bus.readdata = seg_q[bus.address[2:0]];
   end

   assign bus.seg_valid = (state_q == SEND);
   assign bus.seg_data  = (state_q == SEND) ? seg_q[idx_q] : 32'h0;
   assign bus.seg_index = idx_q;
   assign bus.irq       = done_q && irq_en_q;

endmodule
